l2_victim_buffer: RTL

//  Single-entry write-back buffer between the L2 cache and physical memory.

---
 rtl/l2_types_pkg.sv | 19 +
 rtl/l2_victim_buffer_if.sv | 31 +++
 rtl/victim_line_reg.sv | 39 +++
 rtl/l2_victim_buffer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/l2_types_pkg.sv
// Shared widths and line types for the L2 victim buffer slice.
// Line address = byte address with the line-offset bits stripped.
package l2_types_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int LINE_WIDTH  = 256;
    localparam int OFFSET_BITS = 5;
    localparam int LADDR_WIDTH = ADDR_WIDTH - OFFSET_BITS;

    typedef logic [LINE_WIDTH-1:0]  line_t;
    typedef logic [LADDR_WIDTH-1:0] line_addr_t;
    typedef logic [ADDR_WIDTH-1:0]  addr_t;

    // Rebuild a line-aligned byte address from a line address.
    function automatic addr_t line_base(input line_addr_t la);
        return {la, {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/l2_victim_buffer_if.sv
// L2-side request/response and pmem-side bus of the victim buffer.
// slave = the buffer itself; master = the L2 plus memory around it.
interface l2_victim_buffer_if
    import l2_types_pkg::*;
();

    logic  l2_read;
    logic  l2_write;
    addr_t l2_address;
    line_t l2_wdata;
    line_t l2_rdata;
    logic  l2_resp;

    logic  pmem_read;
    logic  pmem_write;
    addr_t pmem_address;
    line_t pmem_wdata;
    line_t pmem_rdata;
    logic  pmem_resp;

    modport slave (
        input  l2_read, l2_write, l2_address, l2_wdata, pmem_rdata, pmem_resp,
        output l2_rdata, l2_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output l2_read, l2_write, l2_address, l2_wdata, pmem_rdata, pmem_resp,
        input  l2_rdata, l2_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/victim_line_reg.sv
// Single buffered line: valid flag, line address and data.
// Load takes priority over clear; the two are never requested together.
module victim_line_reg
    import l2_types_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       clear,
    input  line_addr_t load_addr,
    input  line_t      load_data,
    output logic       valid,
    output line_addr_t addr,
    output line_t      data
);

    logic       valid_reg;
    line_addr_t addr_reg;
    line_t      data_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            addr_reg  <= load_addr;
            data_reg  <= load_data;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign addr  = addr_reg;
    assign data  = data_reg;

endmodule

// File: rtl/l2_victim_buffer.sv
// Single-entry write-back buffer between L2 and pmem: accepts an eviction in one
// cycle, serves read hits locally, forwards misses and drains when L2 is idle.
module l2_victim_buffer
    import l2_types_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    l2_victim_buffer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FETCH = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    line_t      rdata_q_reg, rdata_q_next;

    logic       buf_valid;
    line_addr_t buf_addr;
    line_t      buf_data;
    logic       buf_load;
    logic       buf_clear;
    line_addr_t req_line;
    logic       hit;
    logic       addr_offset_unused;

    assign req_line = bus.l2_address[ADDR_WIDTH-1:OFFSET_BITS];
    assign hit      = buf_valid && (req_line == buf_addr);
    // The buffer works at line granularity, so the offset bits select nothing.
    assign addr_offset_unused = ^bus.l2_address[OFFSET_BITS-1:0];

    victim_line_reg u_line (
        .clk       (clk),
        .reset     (reset),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_addr (req_line),
        .load_data (bus.l2_wdata),
        .valid     (buf_valid),
        .addr      (buf_addr),
        .data      (buf_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            rdata_q_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rdata_q_reg <= rdata_q_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        rdata_q_next     = rdata_q_reg;
        buf_load         = 1'b0;
        buf_clear        = 1'b0;
        bus.l2_resp      = 1'b0;
        bus.l2_rdata     = '0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;

        case (state_reg)
            IDLE: begin
                // A live request always beats the opportunistic drain.
                if (bus.l2_write) begin
                    if (!buf_valid) begin
                        buf_load   = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = DRAIN;
                    end
                end else if (bus.l2_read) begin
                    if (hit) begin
                        rdata_q_next = buf_data;
                        state_next   = RESP;
                    end else begin
                        state_next = FETCH;
                    end
                end else if (buf_valid) begin
                    state_next = DRAIN;
                end
            end

            DRAIN: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = line_base(buf_addr);
                bus.pmem_wdata   = buf_data;
                if (bus.pmem_resp) begin
                    buf_clear  = 1'b1;
                    state_next = IDLE;
                end
            end

            FETCH: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = line_base(req_line);
                if (bus.pmem_resp) begin
                    rdata_q_next = bus.pmem_rdata;
                    state_next   = RESP;
                end
            end

            RESP: begin
                // Requests are ignored here so a held request is not taken twice.
                bus.l2_resp  = 1'b1;
                bus.l2_rdata = rdata_q_reg;
                state_next   = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    illegal_read_write: assert property (
        @(posedge clk) disable iff (!reset) !(bus.l2_read && bus.l2_write)
    );

endmodule
